// File: rtl/z80_bus_sync.sv
// z80_bus_sync: brings the asynchronous Z80 strobes, address and data into the
// clk domain, rejects strobe glitches shorter than FILTER_CYCLES samples and
// emits clean, registered write/read transaction events for the mailbox.
module z80_bus_sync #(
  parameter int SYNC_STAGES   = 2,
  parameter int FILTER_CYCLES = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       z80_write_strobe_b,
  input  logic       z80_read_strobe_b,
  input  logic [7:0] z80_address_bus,
  input  logic [7:0] z80_data_bus_in,
  output logic       wr_pulse,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data,
  output logic       rd_start,
  output logic       rd_active,
  output logic       rd_end,
  output logic [7:0] rd_addr,
  output logic       bus_error,
  output logic [7:0] glitch_count
);

  localparam logic [3:0] FILT = 4'(FILTER_CYCLES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_QUAL = 3'd1,
    WR_ACT  = 3'd2,
    RD_QUAL = 3'd3,
    RD_ACT  = 3'd4,
    ERR     = 3'd5
  } state_t;

  // Saturating increment for the glitch counter (sticks at 255).
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    logic [7:0] r;
    if (v == 8'hFF) begin
      r = 8'hFF;
    end else begin
      r = v + 8'd1;
    end
    return r;
  endfunction

  // Synchroniser chains; index SYNC_STAGES-1 is the oldest (safe) sample.
  logic [SYNC_STAGES-1:0]      wr_sync_r;
  logic [SYNC_STAGES-1:0]      rd_sync_r;
  logic [SYNC_STAGES-1:0][7:0] addr_sync_r;
  logic [SYNC_STAGES-1:0][7:0] data_sync_r;

  logic       wr_s;
  logic       rd_s;
  logic [7:0] addr_s;
  logic [7:0] data_s;

  // FSM state and registered outputs.
  state_t     state_r;
  logic [3:0] cnt_r;
  logic       wr_pulse_r;
  logic [7:0] wr_addr_r;
  logic [7:0] wr_data_r;
  logic       rd_start_r;
  logic       rd_active_r;
  logic       rd_end_r;
  logic [7:0] rd_addr_r;
  logic       bus_error_r;
  logic [7:0] glitch_r;

  // Next-state values computed combinationally.
  state_t     state_next;
  logic [3:0] cnt_next;
  logic       wr_pulse_next;
  logic [7:0] wr_addr_next;
  logic [7:0] wr_data_next;
  logic       rd_start_next;
  logic       rd_active_next;
  logic       rd_end_next;
  logic [7:0] rd_addr_next;
  logic       bus_error_next;
  logic [7:0] glitch_next;
  logic [3:0] cnt_inc;

  assign wr_s   = wr_sync_r[SYNC_STAGES-1];
  assign rd_s   = rd_sync_r[SYNC_STAGES-1];
  assign addr_s = addr_sync_r[SYNC_STAGES-1];
  assign data_s = data_sync_r[SYNC_STAGES-1];

  assign cnt_inc = cnt_r + 4'd1;

  // Shift the asynchronous bus inputs through the synchroniser flops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_sync_r   <= '1;
      rd_sync_r   <= '1;
      addr_sync_r <= '0;
      data_sync_r <= '0;
    end else begin
      wr_sync_r   <= {wr_sync_r[SYNC_STAGES-2:0], z80_write_strobe_b};
      rd_sync_r   <= {rd_sync_r[SYNC_STAGES-2:0], z80_read_strobe_b};
      addr_sync_r <= {addr_sync_r[SYNC_STAGES-2:0], z80_address_bus};
      data_sync_r <= {data_sync_r[SYNC_STAGES-2:0], z80_data_bus_in};
    end
  end

  // State register and registered transaction outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= IDLE;
      cnt_r       <= 4'd0;
      wr_pulse_r  <= 1'b0;
      wr_addr_r   <= 8'd0;
      wr_data_r   <= 8'd0;
      rd_start_r  <= 1'b0;
      rd_active_r <= 1'b0;
      rd_end_r    <= 1'b0;
      rd_addr_r   <= 8'd0;
      bus_error_r <= 1'b0;
      glitch_r    <= 8'd0;
    end else begin
      state_r     <= state_next;
      cnt_r       <= cnt_next;
      wr_pulse_r  <= wr_pulse_next;
      wr_addr_r   <= wr_addr_next;
      wr_data_r   <= wr_data_next;
      rd_start_r  <= rd_start_next;
      rd_active_r <= rd_active_next;
      rd_end_r    <= rd_end_next;
      rd_addr_r   <= rd_addr_next;
      bus_error_r <= bus_error_next;
      glitch_r    <= glitch_next;
    end
  end

  // Qualification FSM: filter strobes, latch address/data, generate events.
  always_comb begin
    state_next     = state_r;
    cnt_next       = cnt_r;
    wr_pulse_next  = 1'b0;
    wr_addr_next   = wr_addr_r;
    wr_data_next   = wr_data_r;
    rd_start_next  = 1'b0;
    rd_active_next = rd_active_r;
    rd_end_next    = 1'b0;
    rd_addr_next   = rd_addr_r;
    bus_error_next = 1'b0;
    glitch_next    = glitch_r;

    case (state_r)
      IDLE: begin
        if (!wr_s && !rd_s) begin
          state_next     = ERR;
          cnt_next       = 4'd0;
          bus_error_next = 1'b1;
        end else if (!wr_s) begin
          cnt_next = 4'd1;
          if (FILT == 4'd1) begin
            state_next   = WR_ACT;
            wr_addr_next = addr_s;
            wr_data_next = data_s;
          end else begin
            state_next = WR_QUAL;
          end
        end else if (!rd_s) begin
          cnt_next = 4'd1;
          if (FILT == 4'd1) begin
            state_next     = RD_ACT;
            rd_addr_next   = addr_s;
            rd_start_next  = 1'b1;
            rd_active_next = 1'b1;
          end else begin
            state_next = RD_QUAL;
          end
        end else begin
          cnt_next = 4'd0;
        end
      end

      WR_QUAL: begin
        if (!wr_s && !rd_s) begin
          state_next     = ERR;
          cnt_next       = 4'd0;
          bus_error_next = 1'b1;
        end else if (!wr_s) begin
          cnt_next = cnt_inc;
          if (cnt_inc == FILT) begin
            // Strobe accepted: the data sample at this edge already counts.
            state_next   = WR_ACT;
            wr_addr_next = addr_s;
            wr_data_next = data_s;
          end else begin
            state_next = WR_QUAL;
          end
        end else begin
          state_next  = IDLE;
          cnt_next    = 4'd0;
          glitch_next = sat_inc(glitch_r);
        end
      end

      WR_ACT: begin
        if (!wr_s && !rd_s) begin
          state_next     = ERR;
          cnt_next       = 4'd0;
          bus_error_next = 1'b1;
        end else if (!wr_s) begin
          wr_data_next = data_s;
        end else begin
          state_next    = IDLE;
          cnt_next      = 4'd0;
          wr_pulse_next = 1'b1;
        end
      end

      RD_QUAL: begin
        if (!wr_s && !rd_s) begin
          state_next     = ERR;
          cnt_next       = 4'd0;
          bus_error_next = 1'b1;
        end else if (!rd_s) begin
          cnt_next = cnt_inc;
          if (cnt_inc == FILT) begin
            state_next     = RD_ACT;
            rd_addr_next   = addr_s;
            rd_start_next  = 1'b1;
            rd_active_next = 1'b1;
          end else begin
            state_next = RD_QUAL;
          end
        end else begin
          state_next  = IDLE;
          cnt_next    = 4'd0;
          glitch_next = sat_inc(glitch_r);
        end
      end

      RD_ACT: begin
        if (!wr_s && !rd_s) begin
          state_next     = ERR;
          cnt_next       = 4'd0;
          bus_error_next = 1'b1;
          rd_active_next = 1'b0;
        end else if (!rd_s) begin
          rd_active_next = 1'b1;
        end else begin
          state_next     = IDLE;
          cnt_next       = 4'd0;
          rd_active_next = 1'b0;
          rd_end_next    = 1'b1;
        end
      end

      ERR: begin
        if (wr_s && rd_s) begin
          state_next = IDLE;
        end else begin
          state_next = ERR;
        end
      end

      default: begin
        state_next     = IDLE;
        cnt_next       = 4'd0;
        rd_active_next = 1'b0;
      end
    endcase
  end

  assign wr_pulse     = wr_pulse_r;
  assign wr_addr      = wr_addr_r;
  assign wr_data      = wr_data_r;
  assign rd_start     = rd_start_r;
  assign rd_active    = rd_active_r;
  assign rd_end       = rd_end_r;
  assign rd_addr      = rd_addr_r;
  assign bus_error    = bus_error_r;
  assign glitch_count = glitch_r;

endmodule

// File: tb/tb_z80_bus_sync.sv
// tb_z80_bus_sync: directed and randomized stimulus for z80_bus_sync, checked
// every cycle against a transaction-level model of the bus front end.
module tb_z80_bus_sync;

  localparam int SS = 2;
  localparam int FC = 3;

  logic       clk = 1'b0;
  logic       reset;
  logic       wsb;
  logic       rsb;
  logic [7:0] abus;
  logic [7:0] dbus;
  logic       wr_pulse;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;
  logic       rd_start;
  logic       rd_active;
  logic       rd_end;
  logic [7:0] rd_addr;
  logic       bus_error;
  logic [7:0] glitch_count;

  always #5 clk = ~clk;

  z80_bus_sync #(.SYNC_STAGES(SS), .FILTER_CYCLES(FC)) dut (
    .clk                (clk),
    .reset              (reset),
    .z80_write_strobe_b (wsb),
    .z80_read_strobe_b  (rsb),
    .z80_address_bus    (abus),
    .z80_data_bus_in    (dbus),
    .wr_pulse           (wr_pulse),
    .wr_addr            (wr_addr),
    .wr_data            (wr_data),
    .rd_start           (rd_start),
    .rd_active          (rd_active),
    .rd_end             (rd_end),
    .rd_addr            (rd_addr),
    .bus_error          (bus_error),
    .glitch_count       (glitch_count)
  );

  int checks   = 0;
  int failures = 0;

  // Event tallies observed from the DUT.
  int n_wrp = 0;
  int n_rds = 0;
  int n_rde = 0;
  int n_be  = 0;
  int n_act = 0;

  // Model: input history (index SS is what the clk domain acts on at an edge).
  logic       h_w [0:SS];
  logic       h_r [0:SS];
  logic [7:0] h_a [0:SS];
  logic [7:0] h_d [0:SS];
  int         m_phase;   // 0 none, 1 write strobe, 2 read strobe, 3 bus error
  int         m_run;     // consecutive low samples of the current strobe
  bit         m_acc;     // current strobe long enough to be a transaction
  logic       m_wr_pulse, m_rd_start, m_rd_end, m_bus_error, m_rd_active;
  logic [7:0] m_wr_addr, m_wr_data, m_rd_addr, m_glitch;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i <= SS; i++) begin
      h_w[i] = 1'b1;
      h_r[i] = 1'b1;
      h_a[i] = 8'h00;
      h_d[i] = 8'h00;
    end
    m_phase = 0; m_run = 0; m_acc = 1'b0;
    m_wr_pulse = 1'b0; m_rd_start = 1'b0; m_rd_end = 1'b0; m_bus_error = 1'b0;
    m_rd_active = 1'b0;
    m_wr_addr = 8'h00; m_wr_data = 8'h00; m_rd_addr = 8'h00; m_glitch = 8'h00;
  endtask

  task automatic glitch_seen();
    if (m_glitch != 8'hFF) m_glitch = m_glitch + 8'd1;
  endtask

  // One clock edge of the model, given the inputs presented before it.
  task automatic model_edge(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    logic ws, rs;
    logic [7:0] sa, sd;
    for (int i = SS; i > 0; i--) begin
      h_w[i] = h_w[i-1]; h_r[i] = h_r[i-1]; h_a[i] = h_a[i-1]; h_d[i] = h_d[i-1];
    end
    h_w[0] = w; h_r[0] = r; h_a[0] = a; h_d[0] = d;
    ws = h_w[SS]; rs = h_r[SS]; sa = h_a[SS]; sd = h_d[SS];
    m_wr_pulse = 1'b0; m_rd_start = 1'b0; m_rd_end = 1'b0; m_bus_error = 1'b0;
    if (m_phase == 3) begin
      if (ws && rs) m_phase = 0;
    end else if (!ws && !rs) begin
      m_phase = 3; m_bus_error = 1'b1; m_rd_active = 1'b0;
    end else if (m_phase == 0 && !ws) begin
      m_phase = 1; m_run = 1; m_acc = (m_run >= FC);
      if (m_acc) begin m_wr_addr = sa; m_wr_data = sd; end
    end else if (m_phase == 0 && !rs) begin
      m_phase = 2; m_run = 1; m_acc = (m_run >= FC);
      if (m_acc) begin m_rd_addr = sa; m_rd_start = 1'b1; m_rd_active = 1'b1; end
    end else if (m_phase == 1) begin
      if (!ws) begin
        m_run++;
        if (!m_acc && m_run >= FC) begin m_acc = 1'b1; m_wr_addr = sa; end
        if (m_acc) m_wr_data = sd;
      end else begin
        if (m_acc) m_wr_pulse = 1'b1;
        else glitch_seen();
        m_phase = 0;
      end
    end else if (m_phase == 2) begin
      if (!rs) begin
        m_run++;
        if (!m_acc && m_run >= FC) begin
          m_acc = 1'b1; m_rd_addr = sa; m_rd_start = 1'b1; m_rd_active = 1'b1;
        end
      end else begin
        if (m_acc) begin m_rd_end = 1'b1; m_rd_active = 1'b0; end
        else glitch_seen();
        m_phase = 0;
      end
    end
  endtask

  // Drive one cycle of inputs (called at a negedge), then compare at the next negedge.
  task automatic step(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d);
    wsb = w; rsb = r; abus = a; dbus = d;
    model_edge(w, r, a, d);
    @(negedge clk);
    chk("cycle_outputs",
        64'({wr_pulse, rd_start, rd_active, rd_end, bus_error, wr_addr, wr_data, rd_addr, glitch_count}),
        64'({m_wr_pulse, m_rd_start, m_rd_active, m_rd_end, m_bus_error, m_wr_addr, m_wr_data, m_rd_addr, m_glitch}));
    checks++;
    if ($countones({wr_pulse, rd_start, rd_end, bus_error}) > 1) begin
      failures++;
      $display("FAIL exclusive_events actual=%b required=at_most_one",
               {wr_pulse, rd_start, rd_end, bus_error});
    end
    if (wr_pulse)  n_wrp++;
    if (rd_start)  n_rds++;
    if (rd_end)    n_rde++;
    if (bus_error) n_be++;
    if (rd_active) n_act++;
  endtask

  task automatic hold(input logic w, input logic r, input logic [7:0] a, input logic [7:0] d, input int n);
    for (int i = 0; i < n; i++) step(w, r, a, d);
  endtask

  task automatic idle(input int n);
    hold(1'b1, 1'b1, 8'h00, 8'h00, n);
  endtask

  initial begin
    int wrp0, rds0, rde0, be0, act0;
    int kind, len, gap;
    logic [7:0] ra;

    reset = 1'b1; wsb = 1'b1; rsb = 1'b1; abus = 8'h00; dbus = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("reset_state",
        64'({wr_pulse, rd_start, rd_active, rd_end, bus_error, wr_addr, wr_data, rd_addr, glitch_count}),
        64'd0);

    // Short write strobe: rejected and counted.
    wrp0 = n_wrp;
    hold(1'b0, 1'b1, 8'h33, 8'h44, 2);
    idle(8);
    chk("glitch_count_one", 64'(glitch_count), 64'd1);
    chk("glitch_no_wr_pulse", 64'(n_wrp - wrp0), 64'd0);

    // Normal write.
    wrp0 = n_wrp;
    hold(1'b0, 1'b1, 8'h80, 8'h5A, 10);
    idle(8);
    chk("write_pulse_count", 64'(n_wrp - wrp0), 64'd1);
    chk("write_addr", 64'(wr_addr), 64'h80);
    chk("write_data", 64'(wr_data), 64'h5A);
    chk("model_write_addr", 64'(m_wr_addr), 64'h80);

    // Data changes while strobe low: last sample wins.
    wrp0 = n_wrp;
    hold(1'b0, 1'b1, 8'h40, 8'h11, 5);
    hold(1'b0, 1'b1, 8'h40, 8'h22, 5);
    idle(8);
    chk("late_data_pulse_count", 64'(n_wrp - wrp0), 64'd1);
    chk("late_data_value", 64'(wr_data), 64'h22);
    chk("model_late_data", 64'(m_wr_data), 64'h22);

    // Read of 12 cycles.
    rds0 = n_rds; rde0 = n_rde; act0 = n_act;
    hold(1'b1, 1'b0, 8'h81, 8'h00, 12);
    idle(8);
    chk("read_start_count", 64'(n_rds - rds0), 64'd1);
    chk("read_end_count", 64'(n_rde - rde0), 64'd1);
    chk("read_active_cycles", 64'(n_act - act0), 64'(12 - FC + 1));
    chk("read_addr", 64'(rd_addr), 64'h81);

    // Both strobes low in the middle of a write.
    wrp0 = n_wrp; be0 = n_be;
    hold(1'b0, 1'b1, 8'h10, 8'hAA, 6);
    hold(1'b0, 1'b0, 8'h10, 8'hAA, 3);
    hold(1'b0, 1'b1, 8'h10, 8'hAA, 3);
    idle(8);
    chk("bus_error_count", 64'(n_be - be0), 64'd1);
    chk("bus_error_no_wr_pulse", 64'(n_wrp - wrp0), 64'd0);
    chk("bus_error_glitch_unchanged", 64'(glitch_count), 64'd1);

    // 300 glitches saturate the counter.
    for (int g = 0; g < 300; g++) begin
      step(1'b0, 1'b1, 8'h00, 8'h00);
      step(1'b1, 1'b1, 8'h00, 8'h00);
    end
    idle(6);
    chk("glitch_saturated", 64'(glitch_count), 64'd255);
    chk("model_glitch_saturated", 64'(m_glitch), 64'd255);

    // Reset in the middle of a read clears rd_active immediately.
    hold(1'b1, 1'b0, 8'h81, 8'h00, 8);
    chk("model_read_in_progress", 64'(m_rd_active), 64'd1);
    #2 reset = 1'b1;
    #1;
    chk("reset_mid_read_rd_active", 64'(rd_active), 64'd0);
    chk("reset_mid_read_outputs",
        64'({wr_pulse, rd_start, rd_active, rd_end, bus_error, wr_addr, wr_data, rd_addr, glitch_count}),
        64'd0);
    wsb = 1'b1; rsb = 1'b1; abus = 8'h00; dbus = 8'h00;
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    idle(4);

    // Randomized transactions, including back-to-back and overlapping strobes.
    for (int t = 0; t < 200; t++) begin
      kind = int'($urandom_range(0, 9));
      len  = int'($urandom_range(1, 8));
      gap  = int'($urandom_range(0, 3));
      ra   = 8'($urandom);
      for (int i = 0; i < len; i++) begin
        if (kind < 5)      step(1'b0, 1'b1, ra, 8'($urandom));
        else if (kind < 9) step(1'b1, 1'b0, ra, 8'($urandom));
        else               step(1'b0, 1'b0, ra, 8'($urandom));
      end
      for (int i = 0; i < gap; i++) step(1'b1, 1'b1, 8'($urandom), 8'($urandom));
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
